// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with a one-deep registered output stage and valid/ready handshakes.
// Define IMM_GEN_SKID_EN to add a one-entry skid buffer that registers in_ready.
module imm_gen_pipe #(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_B   = 3'd0,
    FMT_CB  = 3'd1,
    FMT_D   = 3'd2,
    FMT_I   = 3'd3,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    fmt_e              fmt;
    logic              ill;
  } res_t;

  function automatic res_t decode(input logic [31:0] w);
    logic [63:0] ext;
    res_t        r;
    ext   = '0;
    r.fmt = FMT_ILL;
    r.ill = 1'b0;
    if (w[30:26] == 5'b00101) begin
      ext   = {{38{w[25]}}, w[25:0]};
      r.fmt = FMT_B;
      if (BR_SHIFT != 0) ext = ext << 2;
    end else if (w[31:25] == 7'b1011010) begin
      ext   = {{45{w[23]}}, w[23:5]};
      r.fmt = FMT_CB;
      if (BR_SHIFT != 0) ext = ext << 2;
    end else if (w[31:23] == 9'b111110000 && !w[21]) begin
      ext   = {{55{w[20]}}, w[20:12]};
      r.fmt = FMT_D;
    end else if (w[31] && w[29:23] == 7'b0100010) begin
      ext   = {52'd0, w[21:10]};
      r.fmt = FMT_I;
    end else begin
      r.ill = 1'b1;
    end
    r.imm = ext[DATA_W-1:0];
    return r;
  endfunction

  res_t dec;
  res_t src;
  res_t out_q;
  logic src_valid;
  logic out_free;
  logic accept;

  assign dec      = decode(in_instr);
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef IMM_GEN_SKID_EN
  logic skid_full;
  logic skid_full_n;
  logic ready_q;
  res_t skid_q;

  assign in_ready  = ready_q;
  // The skid always drains first; while it is full in_ready is low, so no new word competes.
  assign src_valid = skid_full || accept;
  assign src       = skid_full ? skid_q : dec;

  always_comb begin
    skid_full_n = skid_full;
    if (out_free)    skid_full_n = 1'b0;
    else if (accept) skid_full_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      skid_full <= skid_full_n;
      ready_q   <= !skid_full_n;
      if (!out_free && accept) skid_q <= dec;
    end
  end
`else
  assign in_ready  = rst_n && out_free;
  assign src_valid = accept;
  assign src       = dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (out_free) begin
      out_valid <= src_valid;
      out_q     <= src_valid ? src : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec.ill && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe: two configurations share stimulus, checked against a queue model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [63:0] imm0;
  logic [31:0] imm1;
  logic [2:0]  fmt0, fmt1;
  logic        ill0, ill1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] q[$];
  int          n_ill = 0;
  int          since_rst = 0;

  always #5 clk = ~clk;

  imm_gen_pipe u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_imm(imm0), .out_fmt(fmt0),
    .out_illegal(ill0), .illegal_cnt(cnt0)
  );

  imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_imm(imm1), .out_fmt(fmt1),
    .out_illegal(ill1), .illegal_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference decode from the format rules, using masks and signed integer arithmetic.
  function automatic void ref_dec(input logic [31:0] w, input int dw, input int sh,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint unsigned f;
    longint          v;
    v   = 0;
    ill = 1'b0;
    fmt = 3'd7;
    if ((w & 32'h7C00_0000) == 32'h1400_0000) begin
      f = 64'(w & 32'h03FF_FFFF);
      v = (f >= 64'h200_0000) ? longint'(f) - longint'(64'h400_0000) : longint'(f);
      if (sh != 0) v = v * 4;
      fmt = 3'd0;
    end else if ((w >> 25) == 32'h5A) begin
      f = 64'((w >> 5) & 32'h7FFFF);
      v = (f >= 64'h40000) ? longint'(f) - longint'(64'h80000) : longint'(f);
      if (sh != 0) v = v * 4;
      fmt = 3'd1;
    end else if ((w & 32'hFFA0_0000) == 32'hF800_0000) begin
      f = 64'((w >> 12) & 32'h1FF);
      v = (f >= 64'h100) ? longint'(f) - longint'(64'h200) : longint'(f);
      fmt = 3'd2;
    end else if ((w & 32'hBF80_0000) == 32'h9100_0000) begin
      v = longint'(64'((w >> 10) & 32'hFFF));
      fmt = 3'd3;
    end else begin
      ill = 1'b1;
    end
    imm = 64'(v);
    if (dw < 64) imm = imm & ((64'd1 << dw) - 64'd1);
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w = (w & 32'h03FF_FFFF) | (($urandom_range(0, 1) != 0) ? 32'h9400_0000 : 32'h1400_0000);
      1: w = (w & 32'h01FF_FFFF) | 32'hB400_0000;
      2: w = (w & ~32'hFFA0_0000) | 32'hF800_0000;
      3: w = (w & ~32'hBF80_0000) | 32'h9100_0000;
      default: ;
    endcase
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) since_rst <= 0;
    else        since_rst <= since_rst + 1;
  end

  // Scoreboard: everything accepted and not yet taken, oldest first.
  always @(negedge clk) begin
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    logic        er;
    if (!rst_n) begin
      q.delete();
      n_ill = 0;
    end else begin
`ifdef IMM_GEN_SKID_EN
      er = (since_rst > 0) && (q.size() < 2);
`else
      er = (q.size() == 0) || out_ready;
`endif
      chk("ovalid0", 64'(out_valid0), 64'(q.size() != 0));
      chk("ovalid1", 64'(out_valid1), 64'(q.size() != 0));
      chk("iready0", 64'(in_ready0), 64'(er));
      chk("iready1", 64'(in_ready1), 64'(er));
      if (q.size() != 0) begin
        ref_dec(q[0], 64, 1, ei, ef, el);
        chk("imm0", imm0, ei);
        chk("fmt0", 64'(fmt0), 64'(ef));
        chk("ill0", 64'(ill0), 64'(el));
        ref_dec(q[0], 32, 0, ei, ef, el);
        chk("imm1", 64'(imm1), ei);
        chk("fmt1", 64'(fmt1), 64'(ef));
        chk("ill1", 64'(ill1), 64'(el));
      end
      chk("cnt0", 64'(cnt0), 64'((n_ill > 65535) ? 65535 : n_ill));
      chk("cnt1", 64'(cnt1), 64'((n_ill > 3) ? 3 : n_ill));
      if (out_valid0 && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready0) begin
        q.push_back(in_instr);
        ref_dec(in_instr, 64, 1, ei, ef, el);
        if (el) n_ill++;
      end
    end
  end

  // Called at posedge+1 with the word presented; returns at posedge+1 after the accept edge.
  task automatic wait_acc();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("accept_timeout", 64'(in_ready0), 64'd1);
  endtask

  task automatic send_chk(input string tag, input logic [31:0] w,
                          input logic [63:0] e0, input logic [31:0] e1, input logic [2:0] ef);
    in_valid = 1'b1;
    in_instr = w;
    wait_acc();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid0), 64'd1);
    chk({tag, "_imm0"}, imm0, e0);
    chk({tag, "_imm1"}, 64'(imm1), 64'(e1));
    chk({tag, "_fmt"}, 64'(fmt0), 64'(ef));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sw[3];
  int          acc_n;
  int          idx;
  logic        acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    sw[0] = 32'h17FF_FFFF;
    sw[1] = 32'hB400_0040;
    sw[2] = 32'hF85F_8000;
    repeat (2) @(negedge clk);
    chk("rst_ovalid", 64'(out_valid0), 64'd0);
    chk("rst_imm", imm0, 64'd0);
    chk("rst_fmt", 64'(fmt0), 64'd0);
    chk("rst_ill", 64'(ill0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_iready", 64'(in_ready0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send_chk("b_neg1", 32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 3'd0);
    send_chk("cbz", 32'hB400_0040, 64'h8, 32'h2, 3'd1);
    send_chk("ldur", 32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2);
    send_chk("addi", 32'h913F_FC00, 64'hFFF, 32'hFFF, 3'd3);
    for (int i = 0; i < 3; i++) send_chk("illegal", 32'h0, 64'd0, 32'd0, 3'd7);
    chk("cnt_3", 64'(cnt0), 64'd3);
    for (int i = 0; i < 2; i++) send_chk("illegal", 32'h0, 64'd0, 32'd0, 3'd7);
    chk("cnt_5", 64'(cnt0), 64'd5);
    chk("cnt_sat", 64'(cnt1), 64'd3);

    // Stall the consumer for four cycles with three words on offer.
    out_ready = 1'b0;
    acc_n = 0;
    idx = 0;
    in_valid = 1'b1;
    in_instr = sw[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = in_ready0;
      if (acc) acc_n++;
      @(posedge clk);
      #1;
      if (acc && idx < 2) begin
        idx++;
        in_instr = sw[idx];
      end
    end
    @(negedge clk);
`ifdef IMM_GEN_SKID_EN
    chk("stall_accepts", 64'(acc_n), 64'd2);
`else
    chk("stall_accepts", 64'(acc_n), 64'd1);
`endif
    chk("stall_iready", 64'(in_ready0), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_acc();
    while (idx < 2) begin
      idx++;
      in_instr = sw[idx];
      wait_acc();
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Fill the pipe under stall, then hit reset between clock edges.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_instr = 32'h0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ovalid", 64'(out_valid0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ovalid", 64'(out_valid0), 64'd0);
    chk("async_cnt", 64'(cnt0), 64'd0);
    chk("async_iready", 64'(in_ready0), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_chk("post_rst", 32'hB400_0040, 64'h8, 32'h2, 3'd1);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_word();
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
